cond_mc_sequencer: RTL and testbench

- Parametrised successor to the processor's control-side condition logic plus multicycle handshake.
- Holds the architectural NZCV flag register and evaluates 4-bit condition codes.
- Gates the writes (PC, register, memory) from the decoder.
- Sequences up to NUNITS multicycle execution units (mul/div/etc.) through a start/done handshake, stalling the datapath until the selected unit finishes.

---
 rtl/cond_mc_sequencer.sv | 263 ++++++++++++++++++++++++++
 tb/tb_cond_mc_sequencer.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cond_mc_sequencer.sv
// cond_mc_sequencer
//   Control-side condition logic plus multicycle-unit sequencer.
//   - Holds the architectural NZCV flag register and evaluates ARM-style
//     4-bit condition codes against it.
//   - Gates the decoder's PC / register / memory write intents.
//   - Launches one of NUNITS multicycle units with a one-cycle start pulse,
//     stalls fetch/decode until that unit reports done, then retires the
//     instruction through a one-cycle writeback slot.
//
//   Optional build macro: MC_TIMEOUT_EN
//     When defined, a WAIT-cycle counter aborts an operation whose unit has
//     not answered within TIMEOUT cycles and raises the sticky
//     mc_timeout_err flag. When undefined there is no counter and WAIT
//     waits indefinitely.
//
//   Handshake: mc_start[i] is a single-cycle registered pulse; the unit
//   answers by holding mc_done[i] high. mc_done is only looked at while in
//   WAIT, and only the bit of the unit that was started is honoured.
//
//   state_dbg exposes the FSM state (0=IDLE, 1=START, 2=WAIT, 3=WB).

`timescale 1ns/1ps

module cond_mc_sequencer #(
    parameter int NUNITS  = 2,
    parameter int OPW     = 2,
    parameter int TIMEOUT = 64,
    localparam int SELW   = (NUNITS > 1) ? $clog2(NUNITS) : 1
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              dec_valid,
    input  logic [3:0]        cond,
    input  logic [3:0]        alu_flags,
    input  logic [1:0]        flag_w,
    input  logic              pcs,
    input  logic              reg_w,
    input  logic              mem_w,
    input  logic              no_write,
    input  logic              mc_req,
    input  logic [SELW-1:0]   mc_sel,
    input  logic [OPW-1:0]    mc_op,
    input  logic [NUNITS-1:0] mc_done,
    output logic              cond_ex,
    output logic              pc_src,
    output logic              reg_write,
    output logic              mem_write,
    output logic              stall,
    output logic [NUNITS-1:0] mc_start,
    output logic [OPW-1:0]    mc_op_out,
    output logic              mc_write,
    output logic [3:0]        flags,
    output logic              mc_busy,
    output logic              mc_timeout_err,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_WB    = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic [3:0]        flags_q;
    logic              cond_pass;

    logic [NUNITS-1:0] sel_oh;      // decoded target unit of the current request
    logic [NUNITS-1:0] sel_oh_q;    // unit owning the in-flight operation
    logic [NUNITS-1:0] start_q;
    logic [OPW-1:0]    op_q;
    logic              wb_reg_q;    // register write intent carried to WB

    logic              req_go;      // a multicycle op is accepted this cycle
    logic              done_sel;    // the owning unit reports done
    logic              abort;       // WAIT gave up on the owning unit

    // Condition evaluation against the registered flags (not alu_flags).
    always_comb begin
        logic n, z, c, v;
        {n, z, c, v} = flags_q;
        cond_pass    = 1'b1;
        case (cond)
            4'b0000: cond_pass = z;                      // EQ
            4'b0001: cond_pass = ~z;                     // NE
            4'b0010: cond_pass = c;                      // CS/HS
            4'b0011: cond_pass = ~c;                     // CC/LO
            4'b0100: cond_pass = n;                      // MI
            4'b0101: cond_pass = ~n;                     // PL
            4'b0110: cond_pass = v;                      // VS
            4'b0111: cond_pass = ~v;                     // VC
            4'b1000: cond_pass = c & ~z;                 // HI
            4'b1001: cond_pass = ~c | z;                 // LS
            4'b1010: cond_pass = (n == v);               // GE
            4'b1011: cond_pass = (n != v);               // LT
            4'b1100: cond_pass = ~z & (n == v);          // GT
            4'b1101: cond_pass = z | (n != v);           // LE
            default: cond_pass = 1'b1;                   // AL and 1111
        endcase
    end

    assign cond_ex = cond_pass;

    // One-hot decode of mc_sel; out-of-range selects fall back to unit 0.
    always_comb begin
        sel_oh = '0;
        for (int i = 0; i < NUNITS; i++) begin
            if (mc_sel == SELW'(i)) begin
                sel_oh[i] = 1'b1;
            end
        end
        if (sel_oh == '0) begin
            sel_oh = NUNITS'(1);
        end
    end

    assign req_go   = (state_q == S_IDLE) & dec_valid & mc_req & cond_pass;
    assign done_sel = |(mc_done & sel_oh_q);

`ifdef MC_TIMEOUT_EN
    localparam int CNTW = $clog2(TIMEOUT + 1);

    logic [CNTW-1:0] wait_cnt_q;
    logic            err_q;

    // Done has priority over the timeout on the final allowed WAIT cycle.
    assign abort = (state_q == S_WAIT) & ~done_sel &
                   (wait_cnt_q == CNTW'(TIMEOUT - 1));

    // WAIT-cycle counter: cleared in START, counts every WAIT cycle.
    always_ff @(posedge CLK) begin
        if (rst) begin
            wait_cnt_q <= '0;
        end else if (state_q == S_START) begin
            wait_cnt_q <= '0;
        end else if (state_q == S_WAIT) begin
            wait_cnt_q <= wait_cnt_q + CNTW'(1);
        end
    end

    // Sticky abort flag, cleared only by reset.
    always_ff @(posedge CLK) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (abort) begin
            err_q <= 1'b1;
        end
    end

    assign mc_timeout_err = err_q;
`else
    assign abort          = 1'b0;
    assign mc_timeout_err = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_go) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (done_sel) begin
                    state_d = S_WB;
                end else if (abort) begin
                    state_d = S_IDLE;
                end
            end
            S_WB: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM outputs: write gating, stall and writeback select.
    always_comb begin
        pc_src    = 1'b0;
        reg_write = 1'b0;
        mem_write = 1'b0;
        stall     = 1'b0;
        mc_write  = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Stall in the request cycle itself so decode holds the op.
                stall = req_go;
                if (dec_valid & ~mc_req & cond_pass) begin
                    pc_src    = pcs;
                    reg_write = reg_w & ~no_write;
                    mem_write = mem_w;
                end
            end
            S_START, S_WAIT: begin
                stall = 1'b1;
            end
            S_WB: begin
                mc_write  = 1'b1;
                reg_write = wb_reg_q;
            end
            default: begin
                stall = 1'b0;
            end
        endcase
    end

    // Request-time latches and the registered start pulse.
    always_ff @(posedge CLK) begin
        if (rst) begin
            start_q  <= '0;
            sel_oh_q <= '0;
            op_q     <= '0;
            wb_reg_q <= 1'b0;
        end else begin
            start_q <= req_go ? sel_oh : '0;
            if (req_go) begin
                sel_oh_q <= sel_oh;
                op_q     <= mc_op;
                wb_reg_q <= reg_w & ~no_write;
            end
        end
    end

    // NZCV register: only executed single-cycle instructions update it.
    always_ff @(posedge CLK) begin
        if (rst) begin
            flags_q <= 4'b0000;
        end else if (dec_valid & cond_pass & ~mc_req) begin
            if (flag_w[1]) begin
                flags_q[3:2] <= alu_flags[3:2];
            end
            if (flag_w[0]) begin
                flags_q[1:0] <= alu_flags[1:0];
            end
        end
    end

    assign mc_start  = start_q;
    assign mc_op_out = op_q;
    assign flags     = flags_q;
    assign mc_busy   = (state_q != S_IDLE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_cond_mc_sequencer.sv
// tb_cond_mc_sequencer
//   Directed scenarios followed by randomized instruction streams, all
//   compared each cycle against a transaction-level model of the sequencer.
//   Build with +define+MC_TIMEOUT_EN to include the timeout scenario.

`timescale 1ns/1ps

module tb_cond_mc_sequencer;

    localparam int NUNITS  = 3;
    localparam int OPW     = 2;
    localparam int TIMEOUT = 8;
    localparam int SELW    = 2;
    localparam int W       = NUNITS + OPW;
`ifdef MC_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic              CLK = 1'b0;
    logic              rst;
    logic              dec_valid;
    logic [3:0]        cond;
    logic [3:0]        alu_flags;
    logic [1:0]        flag_w;
    logic              pcs, reg_w, mem_w, no_write, mc_req;
    logic [SELW-1:0]   mc_sel;
    logic [OPW-1:0]    mc_op;
    logic [NUNITS-1:0] mc_done;
    logic              cond_ex, pc_src, reg_write, mem_write, stall;
    logic [NUNITS-1:0] mc_start;
    logic [OPW-1:0]    mc_op_out;
    logic              mc_write;
    logic [3:0]        flags;
    logic              mc_busy, mc_timeout_err;
    logic [1:0]        state_dbg;

    always #5 CLK = ~CLK;

    cond_mc_sequencer #(.NUNITS(NUNITS), .OPW(OPW), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .rst(rst), .dec_valid(dec_valid), .cond(cond),
        .alu_flags(alu_flags), .flag_w(flag_w), .pcs(pcs), .reg_w(reg_w),
        .mem_w(mem_w), .no_write(no_write), .mc_req(mc_req), .mc_sel(mc_sel),
        .mc_op(mc_op), .mc_done(mc_done), .cond_ex(cond_ex), .pc_src(pc_src),
        .reg_write(reg_write), .mem_write(mem_write), .stall(stall),
        .mc_start(mc_start), .mc_op_out(mc_op_out), .mc_write(mc_write),
        .flags(flags), .mc_busy(mc_busy), .mc_timeout_err(mc_timeout_err),
        .state_dbg(state_dbg)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;
    bit hold   = 1'b0;
    logic [W-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Transaction view: an op is "active" from the request edge; phase 1 is
    // the start cycle, phase 2 waiting for its unit, phase 3 the writeback.
    logic [3:0]        m_flags  = 4'b0000;
    bit                m_act    = 1'b0;
    int                m_ph     = 0;
    int                m_wc     = 0;
    logic [NUNITS-1:0] m_sel_oh = '0;
    logic [OPW-1:0]    m_op     = '0;
    bit                m_wr     = 1'b0;
    bit                m_err    = 1'b0;

    bit                e_cond, e_pc, e_rw, e_mw, e_stall, e_mcw, e_busy;
    logic [NUNITS-1:0] e_start;

    // ARM condition: cond[3:1] picks a test, cond[0] inverts it (except AL).
    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cf, v, base;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cf;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cf && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: return 1'b1;
        endcase
        return base ^ c[0];
    endfunction

    task automatic model_outputs();
        bit cp;
        cp      = cond_ok(cond, m_flags);
        e_cond  = cp;
        e_busy  = m_act;
        e_pc    = 1'b0; e_rw = 1'b0; e_mw = 1'b0;
        e_mcw   = 1'b0; e_stall = 1'b0; e_start = '0;
        if (!m_act) begin
            e_stall = dec_valid && mc_req && cp;
            if (dec_valid && !mc_req && cp) begin
                e_pc = pcs;
                e_rw = reg_w && !no_write;
                e_mw = mem_w;
            end
        end else if (m_ph == 1) begin
            e_start = m_sel_oh;
            e_stall = 1'b1;
        end else if (m_ph == 2) begin
            e_stall = 1'b1;
        end else begin
            e_mcw = 1'b1;
            e_rw  = m_wr;
        end
    endtask

    task automatic model_update();
        bit cp;
        cp = cond_ok(cond, m_flags);
        if (rst) begin
            m_flags = '0; m_act = 0; m_ph = 0; m_wc = 0;
            m_sel_oh = '0; m_op = '0; m_wr = 0; m_err = 0;
            return;
        end
        if (dec_valid && cp && !mc_req) begin
            if (flag_w[1]) m_flags[3:2] = alu_flags[3:2];
            if (flag_w[0]) m_flags[1:0] = alu_flags[1:0];
        end
        if (!m_act) begin
            if (dec_valid && mc_req && cp) begin
                m_act    = 1'b1;
                m_ph     = 1;
                m_sel_oh = (int'(mc_sel) < NUNITS) ? (NUNITS'(1) << mc_sel) : NUNITS'(1);
                m_op     = mc_op;
                m_wr     = reg_w && !no_write;
                exp_q.push_back({m_sel_oh, m_op});
            end
        end else if (m_ph == 1) begin
            m_ph = 2;
            m_wc = 0;
        end else if (m_ph == 2) begin
            if ((mc_done & m_sel_oh) != '0) begin
                m_ph = 3;
            end else if (TO_EN && m_wc == TIMEOUT - 1) begin
                m_act = 1'b0; m_ph = 0; m_err = 1'b1;
            end else begin
                m_wc++;
            end
        end else begin
            m_act = 1'b0;
            m_ph  = 0;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_instr(input logic dv, input logic [3:0] c, input logic [1:0] fw,
                             input logic [3:0] alu, input logic p, input logic r,
                             input logic m, input logic nw, input logic req,
                             input logic [SELW-1:0] s, input logic [OPW-1:0] o);
        dec_valid = dv; cond = c; flag_w = fw; alu_flags = alu;
        pcs = p; reg_w = r; mem_w = m; no_write = nw; mc_req = req;
        mc_sel = s; mc_op = o;
    endtask

    // One cycle: inputs already driven after the falling edge; compare,
    // then let the rising edge happen and advance the model.
    task automatic step();
        logic [W-1:0] got;
        #1;
        model_outputs();
        if (chk_en) begin
            chk("cond_ex",   32'(cond_ex),        32'(e_cond));
            chk("pc_src",    32'(pc_src),         32'(e_pc));
            chk("reg_write", 32'(reg_write),      32'(e_rw));
            chk("mem_write", 32'(mem_write),      32'(e_mw));
            chk("stall",     32'(stall),          32'(e_stall));
            chk("mc_write",  32'(mc_write),       32'(e_mcw));
            chk("mc_start",  32'(mc_start),       32'(e_start));
            chk("mc_op_out", 32'(mc_op_out),      32'(m_op));
            chk("flags",     32'(flags),          32'(m_flags));
            chk("mc_busy",   32'(mc_busy),        32'(e_busy));
            chk("tmo_err",   32'(mc_timeout_err), 32'(m_err));
            if (mc_start != '0) begin
                if (exp_q.size() == 0) begin
                    chk("start_unexp", 32'(mc_start), 32'd0);
                end else begin
                    got = exp_q.pop_front();
                    chk("start_txn", 32'({mc_start, mc_op_out}), 32'(got));
                end
            end
        end
        hold = e_stall;
        @(posedge CLK);
        model_update();
        @(negedge CLK);
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        mc_done = '0;
        set_instr(0, 4'b1110, 2'b00, 4'b0000, 0, 0, 0, 0, 0, 2'd0, 2'd0);
        @(negedge CLK);
        step();                 // DUT outputs unknown before the first edge
        chk_en = 1'b1;
        #1;
        chk("rst_flags", 32'(flags), 32'd0);
        chk("rst_start", 32'(mc_start), 32'd0);
        chk("rst_op",    32'(mc_op_out), 32'd0);
        chk("rst_busy",  32'(mc_busy), 32'd0);
        chk("rst_err",   32'(mc_timeout_err), 32'd0);
        step();
        rst = 1'b0;

        // Flag load through AL, then EQ / NE against the loaded Z.
        set_instr(1, 4'b1110, 2'b11, 4'b0100, 0, 0, 0, 0, 0, 2'd0, 2'd0);
        step();
        chk("flags_load", 32'(flags), 32'h4);
        set_instr(1, 4'b0000, 2'b00, 4'b0000, 0, 1, 0, 0, 0, 2'd0, 2'd0);
        #1;
        chk("eq_cond", 32'(cond_ex), 32'd1);
        chk("eq_regw", 32'(reg_write), 32'd1);
        step();
        set_instr(1, 4'b0001, 2'b00, 4'b0000, 0, 1, 0, 0, 0, 2'd0, 2'd0);
        #1;
        chk("ne_regw", 32'(reg_write), 32'd0);
        step();

        // Multicycle op on unit 1, done arrives on the third WAIT cycle.
        set_instr(1, 4'b1110, 2'b00, 4'b0000, 0, 1, 0, 0, 1, 2'd1, 2'b10);
        #1;
        chk("req_stall", 32'(stall), 32'd1);
        step();
        #1;
        chk("start_u1", 32'(mc_start), 32'b010);
        chk("start_op", 32'(mc_op_out), 32'b10);
        step();
        #1;
        chk("start_once", 32'(mc_start), 32'd0);
        chk("wait_stall", 32'(stall), 32'd1);
        steps(2);
        mc_done = 3'b010;
        step();
        mc_done = '0;
        #1;
        chk("wb_mcw",   32'(mc_write), 32'd1);
        chk("wb_regw",  32'(reg_write), 32'd1);
        chk("wb_stall", 32'(stall), 32'd0);
        chk("wb_op",    32'(mc_op_out), 32'b10);
        step();

        // Clear Z, then a failing EQ multicycle op becomes a NOP.
        set_instr(1, 4'b1110, 2'b10, 4'b0000, 0, 0, 0, 0, 0, 2'd0, 2'd0);
        step();
        set_instr(1, 4'b0000, 2'b00, 4'b0000, 1, 1, 1, 0, 1, 2'd1, 2'd1);
        #1;
        chk("nop_stall", 32'(stall), 32'd0);
        chk("nop_regw",  32'(reg_write), 32'd0);
        step();
        set_instr(0, 4'b1110, 2'b00, 4'b0000, 0, 0, 0, 0, 0, 2'd0, 2'd0);
        #1;
        chk("nop_start", 32'(mc_start), 32'd0);
        chk("nop_busy",  32'(mc_busy), 32'd0);
        step();

        // Out-of-range select -> unit 0; foreign done ignored; no flag write.
        set_instr(1, 4'b1110, 2'b11, 4'b1111, 0, 1, 0, 1, 1, 2'd3, 2'd1);
        step();
        #1;
        chk("oor_start", 32'(mc_start), 32'b001);
        step();
        mc_done = 3'b010;
        step();
        mc_done = '0;
        #1;
        chk("ign_busy", 32'(mc_busy), 32'd1);
        chk("ign_wb",   32'(mc_write), 32'd0);
        mc_done = 3'b001;
        step();
        mc_done = '0;
        #1;
        chk("u0_wb",    32'(mc_write), 32'd1);
        chk("nw_regw",  32'(reg_write), 32'd0);
        step();
        chk("mc_flags", 32'(flags), 32'd0);

        // Reset in the middle of WAIT abandons the op.
        set_instr(1, 4'b1110, 2'b00, 4'b0000, 0, 1, 0, 0, 1, 2'd2, 2'd3);
        steps(3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_instr(0, 4'b1110, 2'b00, 4'b0000, 0, 0, 0, 0, 0, 2'd0, 2'd0);
        #1;
        chk("mrst_stall", 32'(stall), 32'd0);
        chk("mrst_mcw",   32'(mc_write), 32'd0);
        chk("mrst_regw",  32'(reg_write), 32'd0);
        chk("mrst_busy",  32'(mc_busy), 32'd0);
        mc_done = 3'b100;
        step();
        mc_done = '0;
        step();
        chk("late_done", 32'(mc_write), 32'd0);

`ifdef MC_TIMEOUT_EN
        // Unit never answers: abort after TIMEOUT WAIT cycles, sticky error.
        set_instr(1, 4'b1110, 2'b00, 4'b0000, 0, 1, 0, 0, 1, 2'd0, 2'd1);
        steps(2 + TIMEOUT);
        set_instr(0, 4'b1110, 2'b00, 4'b0000, 0, 0, 0, 0, 0, 2'd0, 2'd0);
        #1;
        chk("to_busy",  32'(mc_busy), 32'd0);
        chk("to_err",   32'(mc_timeout_err), 32'd1);
        chk("to_mcw",   32'(mc_write), 32'd0);
        chk("to_stall", 32'(stall), 32'd0);
        steps(2);
        set_instr(1, 4'b1110, 2'b00, 4'b0000, 0, 1, 0, 0, 1, 2'd1, 2'd2);
        steps(2);
        mc_done = 3'b010;
        step();
        mc_done = '0;
        #1;
        chk("to_next_wb",  32'(mc_write), 32'd1);
        chk("to_err_kept", 32'(mc_timeout_err), 32'd1);
        step();
        set_instr(0, 4'b1110, 2'b00, 4'b0000, 0, 0, 0, 0, 0, 2'd0, 2'd0);
        step();
`endif

        // Random instruction stream; the decoder holds while stalled.
        hold = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!hold) begin
                set_instr(logic'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                          2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          logic'($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
                          2'($urandom_range(0, 3)));
            end
            mc_done = NUNITS'($urandom_range(0, 7) & $urandom_range(0, 7));
            rst = ($urandom_range(0, 499) == 0);
            step();
        end
        rst = 1'b0;
        dec_valid = 1'b0;
        mc_done = '1;
        steps(4);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
